// File: rtl/uart_rx_frame.sv
// Purpose: deserialise start/data/control/stop frames from an oversampled serial line.
// Latency: rx_valid one clock after the stop-bit mid-sample tick; rx adds 2 sync clocks.
// Backpressure: none; each frame is a one-cycle pulse and the outputs hold until the next frame.
module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 check_error,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Two-flop synchroniser; resets to the idle-high line level.
  logic rx_meta;
  logic rxs;

  state_t              state;
  state_t              state_nxt;
  logic [TW-1:0]       tick_cnt;
  logic [TW-1:0]       tick_cnt_nxt;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       bit_cnt_nxt;
  // Data bits land in [DATA_BITS-1:0], the control bit in [DATA_BITS].
  logic [DATA_BITS:0]  shift;
  logic [DATA_BITS:0]  shift_nxt;
  // Set only once the line has been seen high; blocks starts on a held-low line.
  logic                armed;
  logic                armed_nxt;
  // High on the stop-bit mid-sample tick.
  logic                frame_done;

  // Bring the asynchronous line into the clock domain.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // State, counters, shift register and arming flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      armed    <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      armed    <= armed_nxt;
    end
  end

  // Next-state logic; nothing moves except on oversampling ticks.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    armed_nxt    = armed;
    frame_done   = 1'b0;
    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (rxs) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            state_nxt    = START;
            tick_cnt_nxt = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_TICK) begin
            if (rxs) begin
              // Line went back high before mid-start: treat as a glitch.
              state_nxt = IDLE;
            end else begin
              state_nxt    = DATA;
              tick_cnt_nxt = '0;
              bit_cnt_nxt  = '0;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == LAST_TICK) begin
            shift_nxt    = {rxs, shift[DATA_BITS:1]};
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state_nxt = STOP;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == LAST_TICK) begin
            state_nxt  = IDLE;
            // A low stop bit leaves the receiver disarmed until the line recovers.
            armed_nxt  = rxs;
            frame_done = 1'b1;
          end else begin
            tick_cnt_nxt = tick_cnt + TW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Publish the completed frame; flags are captured together with the byte.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out    <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      check_error <= 1'b0;
    end else begin
      rx_valid <= frame_done;
      if (frame_done) begin
        data_out    <= shift[DATA_BITS-1:0];
        frame_error <= ~rxs;
        check_error <= shift[DATA_BITS] ^ (&shift[DATA_BITS-1:0]);
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven bit by bit on rx_tick boundaries,
// expected results are queued at drive time and popped when rx_valid pulses.
// One tick every 4 clocks, 16 ticks per bit.
module tb_uart_rx_frame;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       ce;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       rx;
  logic       rx_tick;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_error;
  logic       check_error;
  logic       rx_busy;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  uart_rx_frame #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_tick    (rx_tick),
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .check_error(check_error),
    .rx_busy    (rx_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One-cycle tick every fourth clock, driven on the falling edge.
  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clock);
      rx_tick = 1'b1;
      @(negedge clock);
      rx_tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Wait for n rising edges that carry a tick, then step off the edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clock); while (rx_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic ctrl, input logic stop_b);
    exp_t e;
    e.d  = d;
    e.fe = ~stop_b;
    e.ce = ctrl ^ (&d);
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(ctrl);
    drive_bit(stop_b);
  endtask

  task automatic expect_drained(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clock);
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(data_out), 32'd0);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_fe"}, 32'(frame_error), 32'd0);
    check({tag, "_ce"}, 32'(check_error), 32'd0);
    check({tag, "_busy"}, 32'(rx_busy), 32'd0);
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest queued frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && rx_valid === 1'b1) begin
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data_out", 32'(data_out), 32'(e.d));
          check("frame_error", 32'(frame_error), 32'(e.fe));
          check("check_error", 32'(check_error), 32'(e.ce));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    wait_ticks(20);
    check("idle_busy", 32'(rx_busy), 32'd0);

    // Clean frames and control-bit checking.
    send_frame(8'h55, 1'b0, 1'b1);
    expect_drained("drain_55");
    send_frame(8'hFF, 1'b1, 1'b1);
    expect_drained("drain_ff_ok");
    send_frame(8'hFF, 1'b0, 1'b1);
    expect_drained("drain_ff_bad");

    // Framing error followed by a held-low line.
    send_frame(8'hA3, 1'b0, 1'b0);
    wait_ticks(40);
    check("break_busy", 32'(rx_busy), 32'd0);
    check("break_data_held", 32'(data_out), 32'hA3);
    check("break_fe_held", 32'(frame_error), 32'd1);
    expect_drained("drain_a3");
    rx = 1'b1;
    wait_ticks(20);
    send_frame(8'h3C, 1'b0, 1'b1);
    expect_drained("drain_3c");

    // Start-bit glitch.
    wait_ticks(4);
    rx = 1'b0;
    wait_ticks(3);
    check("glitch_busy_hi", 32'(rx_busy), 32'd1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(8);
    check("glitch_busy_lo", 32'(rx_busy), 32'd0);
    wait_ticks(10);
    send_frame(8'h12, 1'b0, 1'b1);
    expect_drained("drain_12");

    // Back-to-back frames with no idle gap.
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b1);
    expect_drained("drain_b2b");

    // Reset in the middle of a third frame.
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("midreset");
    rx      = 1'b1;
    reset_n = 1'b1;
    wait_ticks(20);
    check("post_reset_busy", 32'(rx_busy), 32'd0);
    send_frame(8'h7E, 1'b0, 1'b1);
    expect_drained("drain_7e");
    wait_ticks(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
